// File: rtl/branch_update_unit.sv
// -----------------------------------------------------------------------------
// branch_update_unit
// Write-side companion of the gshare pattern history table. Accepts resolved
// branches from execute, forms the PHT index (PC[INDEX_LEN+1:2] XOR the
// prediction-time history), queues the updates in a small FIFO and drains one
// per cycle into the PHT write port through a registered output stage. Also
// keeps the committed global history and flags mispredictions for recovery.
//
// Optional feature: define BRANCH_STATS_EN to add saturating 16-bit counters
// of accepted branches and accepted mispredictions.
// -----------------------------------------------------------------------------
module branch_update_unit #(
  parameter int INDEX_LEN  = 10,
  parameter int HIST_LEN   = 10,
  parameter int PC_LEN     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_resolve_valid,
  output logic                 o_resolve_ready,
  input  logic [PC_LEN-1:0]    i_resolve_pc,
  input  logic                 i_resolve_taken,
  input  logic                 i_resolve_pred_taken,
  input  logic [HIST_LEN-1:0]  i_resolve_ghr,
  output logic [INDEX_LEN-1:0] o_index_write,
  output logic                 o_increment_decrement,
  output logic                 o_write_enabled,
  output logic [HIST_LEN-1:0]  o_ghr,
  output logic                 o_mispredict,
  output logic [HIST_LEN-1:0]  o_recover_ghr,
`ifdef BRANCH_STATS_EN
  output logic [15:0]          o_stat_branches,
  output logic [15:0]          o_stat_mispredicts,
`endif
  output logic                 o_queue_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INDEX_LEN-1:0] idx;
    logic                 taken;
  } entry_t;

  entry_t               r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_mispredict;
  entry_t               w_entry;
  logic [HIST_LEN-1:0]  w_ghr_next;
  logic [HIST_LEN-1:0]  w_recover_next;
  logic                 w_unused_pc;

  // Ready is a pure function of occupancy, so a push is refused while full
  // even if the head is popped on the same edge.
  assign w_full          = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_resolve_ready = !w_full;
  assign w_push          = i_resolve_valid && !w_full;
  assign w_pop           = (r_count != '0);
  assign w_mispredict    = (i_resolve_taken != i_resolve_pred_taken);

  // History is XORed into the low HIST_LEN index bits only; zero-extension
  // leaves the upper PC bits untouched, and XOR never carries.
  assign w_entry.idx   = i_resolve_pc[INDEX_LEN+1:2] ^ INDEX_LEN'(i_resolve_ghr);
  assign w_entry.taken = i_resolve_taken;

  // Shift the outcome in at bit 0; the truncating cast drops the oldest bit
  // and stays legal for HIST_LEN == 1.
  assign w_ghr_next     = HIST_LEN'({o_ghr, i_resolve_taken});
  assign w_recover_next = HIST_LEN'({i_resolve_ghr, i_resolve_taken});

  // PC alignment bits and bits above the index field do not affect the index.
  assign w_unused_pc = ^{i_resolve_pc[1:0], i_resolve_pc >> (INDEX_LEN + 2)};

  // Nothing is pending once the queue is empty and the output stage is idle.
  assign o_queue_empty = (r_count == '0) && !o_write_enabled;

  // Queue storage write.
  // NOTE: the storage array has no reset; validity is tracked solely by the
  // pointers and count, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_entry;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered PHT write port: strobe for one cycle per popped entry, hold
  // index and direction otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_write_enabled       <= 1'b0;
      o_index_write         <= '0;
      o_increment_decrement <= 1'b0;
    end else begin
      o_write_enabled <= w_pop;
      if (w_pop) begin
        o_index_write         <= r_fifo[r_rd_ptr].idx;
        o_increment_decrement <= r_fifo[r_rd_ptr].taken;
      end
    end
  end

  // Committed history and misprediction pulse, updated at acceptance time so
  // they never wait on the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ghr         <= '0;
      o_mispredict  <= 1'b0;
      o_recover_ghr <= '0;
    end else begin
      o_mispredict <= w_push && w_mispredict;
      if (w_push) begin
        o_ghr <= w_ghr_next;
        if (w_mispredict) begin
          o_recover_ghr <= w_recover_next;
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating branch and misprediction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_branches    <= '0;
      o_stat_mispredicts <= '0;
    end else if (w_push) begin
      if (o_stat_branches != 16'hFFFF) begin
        o_stat_branches <= o_stat_branches + 16'd1;
      end
      if (w_mispredict && (o_stat_mispredicts != 16'hFFFF)) begin
        o_stat_mispredicts <= o_stat_mispredicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_update_unit
// Scoreboard bench: the stimulus process advances a queue-level reference model
// every cycle and pushes the expected post-edge outputs; a separate monitor
// pops and compares after each rising edge. Define BRANCH_STATS_EN to also
// exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_update_unit;

  localparam int IL    = 10;
  localparam int HL    = 10;
  localparam int PL    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          resolve_valid = 1'b0;
  logic          resolve_ready;
  logic [PL-1:0] resolve_pc = '0;
  logic          resolve_taken = 1'b0;
  logic          resolve_pred_taken = 1'b0;
  logic [HL-1:0] resolve_ghr = '0;
  logic [IL-1:0] index_write;
  logic          increment_decrement;
  logic          write_enabled;
  logic [HL-1:0] ghr;
  logic          mispredict;
  logic [HL-1:0] recover_ghr;
  logic          queue_empty;
`ifdef BRANCH_STATS_EN
  logic [15:0]   stat_branches;
  logic [15:0]   stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_update_unit #(
    .INDEX_LEN(IL), .HIST_LEN(HL), .PC_LEN(PL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_resolve_valid       (resolve_valid),
    .o_resolve_ready       (resolve_ready),
    .i_resolve_pc          (resolve_pc),
    .i_resolve_taken       (resolve_taken),
    .i_resolve_pred_taken  (resolve_pred_taken),
    .i_resolve_ghr         (resolve_ghr),
    .o_index_write         (index_write),
    .o_increment_decrement (increment_decrement),
    .o_write_enabled       (write_enabled),
    .o_ghr                 (ghr),
    .o_mispredict          (mispredict),
    .o_recover_ghr         (recover_ghr),
`ifdef BRANCH_STATS_EN
    .o_stat_branches       (stat_branches),
    .o_stat_mispredicts    (stat_mispredicts),
`endif
    .o_queue_empty         (queue_empty)
  );

  // Expected outputs after one clock edge.
  typedef struct {
    bit we;
    int idx;
    bit inc;
    bit mis;
    int rec;
    int ghr;
    bit ready;
    bit empty;
    int st_br;
    int st_mis;
  } exp_t;

  // One pending PHT update in the reference queue.
  typedef struct {
    int idx;
    bit taken;
  } ent_t;

  exp_t exp_q[$];
  ent_t fifo_q[$];

  int m_ghr, m_idx, m_rec, m_br, m_mis;
  bit m_inc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fifo_q.delete();
    m_ghr = 0; m_idx = 0; m_rec = 0; m_br = 0; m_mis = 0; m_inc = 0;
  endtask

  // Drive one cycle of stimulus and record what the next edge must produce.
  task automatic cycle(input bit v, input logic [31:0] pc, input bit t, input bit p,
                       input logic [HL-1:0] g);
    exp_t e;
    ent_t ent;
    bit   acc;
    @(posedge clk);
    #1;
    resolve_valid      = v;
    resolve_pc         = pc;
    resolve_taken      = t;
    resolve_pred_taken = p;
    resolve_ghr        = g;
    @(negedge clk);
    acc  = v && (fifo_q.size() < DEPTH);
    e.we = 0;
    if (fifo_q.size() > 0) begin
      ent   = fifo_q.pop_front();
      e.we  = 1;
      m_idx = ent.idx;
      m_inc = ent.taken;
    end
    if (acc) begin
      ent.idx   = int'((pc / 32'd4) % 32'd1024) ^ int'(g);
      ent.taken = t;
      fifo_q.push_back(ent);
      m_ghr = (m_ghr * 2 + int'(t)) % 1024;
      if (t != p) m_rec = (int'(g) * 2 + int'(t)) % 1024;
      if (m_br < 65535) m_br++;
      if (t != p && m_mis < 65535) m_mis++;
    end
    e.mis    = acc && (t != p);
    e.idx    = m_idx;
    e.inc    = m_inc;
    e.rec    = m_rec;
    e.ghr    = m_ghr;
    e.ready  = fifo_q.size() < DEPTH;
    e.empty  = (fifo_q.size() == 0) && !e.we;
    e.st_br  = m_br;
    e.st_mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 0, '0);
  endtask

  task automatic do_reset();
    resolve_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_enabled", 32'(write_enabled), 32'(e.we));
        check("index_write", 32'(index_write), 32'(e.idx));
        check("increment_decrement", 32'(increment_decrement), 32'(e.inc));
        check("mispredict", 32'(mispredict), 32'(e.mis));
        check("recover_ghr", 32'(recover_ghr), 32'(e.rec));
        check("ghr", 32'(ghr), 32'(e.ghr));
        check("resolve_ready", 32'(resolve_ready), 32'(e.ready));
        check("queue_empty", 32'(queue_empty), 32'(e.empty));
`ifdef BRANCH_STATS_EN
        check("stat_branches", 32'(stat_branches), 32'(e.st_br));
        check("stat_mispredicts", 32'(stat_mispredicts), 32'(e.st_mis));
`endif
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state, sampled directly.
    check("rst write_enabled", 32'(write_enabled), 32'd0);
    check("rst index_write", 32'(index_write), 32'd0);
    check("rst inc_dec", 32'(increment_decrement), 32'd0);
    check("rst ghr", 32'(ghr), 32'd0);
    check("rst mispredict", 32'(mispredict), 32'd0);
    check("rst recover_ghr", 32'(recover_ghr), 32'd0);
    check("rst ready", 32'(resolve_ready), 32'd1);
    check("rst queue_empty", 32'(queue_empty), 32'd1);
    idle(10);

    // Index formation, correctly predicted taken branch.
    cycle(1, 32'h404, 1, 1, 10'h0F0);
    idle(1);
    check("t2 mispredict", 32'(mispredict), 32'd0);
    check("t2 ghr", 32'(ghr), 32'h001);
    idle(1);
    check("t2 write_enabled", 32'(write_enabled), 32'd1);
    check("t2 index_write", 32'(index_write), 32'h1F1);
    check("t2 inc_dec", 32'(increment_decrement), 32'd1);
    idle(2);

    // Misprediction with full-ones history.
    cycle(1, 32'h8, 0, 1, 10'h3FF);
    idle(1);
    check("t3 mispredict", 32'(mispredict), 32'd1);
    check("t3 recover_ghr", 32'(recover_ghr), 32'h3FE);
    idle(1);
    check("t3 mispredict pulse", 32'(mispredict), 32'd0);
    check("t3 write_enabled", 32'(write_enabled), 32'd1);
    check("t3 index_write", 32'(index_write), 32'h3FD);
    check("t3 inc_dec", 32'(increment_decrement), 32'd0);
    idle(2);

    // Five back-to-back accepts with the drain running.
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h1000 + 32'(i * 4), i[0], 1'b0, 10'(i * 37));
    idle(4);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++)
      cycle(1, $urandom, i[0], 1'b1, 10'($urandom));
    resolve_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5 write_enabled", 32'(write_enabled), 32'd0);
    check("t5 queue_empty", 32'(queue_empty), 32'd1);
    check("t5 ghr", 32'(ghr), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5 post queue_empty", 32'(queue_empty), 32'd1);
    check("t5 post ghr", 32'(ghr), 32'd0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      t = 1'($urandom);
      cycle(($urandom % 10) < 7, $urandom, t, ($urandom % 3 == 0) ? !t : t,
            10'($urandom));
      if ($urandom % 50 == 0) idle(3);
    end
    idle(4);

`ifdef BRANCH_STATS_EN
    // Saturation of the statistics counters.
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      t = 1'($urandom);
      cycle(1, $urandom, t, (i % 4 == 3) ? !t : t, 10'($urandom));
    end
    idle(3);
    check("t6 stat_branches", 32'(stat_branches), 32'hFFFF);
    check("t6 stat_mispredicts", 32'(stat_mispredicts), 32'd17500);
`endif

    idle(2);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
